// File: rtl/sb_cfg_loader.sv
// Serial configuration loader for one switch box: shifts in an MSB-first word
// plus an even-parity bit, then commits it to prog when the datapath allows.
module sb_cfg_loader #(
  parameter int PROG_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  input  logic              cfg_abort,
  input  logic              apply_ok,
  output logic [PROG_W-1:0] prog,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int CNT_W = $clog2(PROG_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PROG_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    COMMIT
  } state_t;

  state_t             state, state_next;
  logic [PROG_W-1:0]  shadow, shadow_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [PROG_W-1:0]  prog_next;
  logic               busy_next, done_next, err_next;

  // Next-state and next-output logic. Abort outranks every other input in any
  // non-IDLE state, so it is tested first in each branch.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_next  = state;
    shadow_next = shadow;
    count_next  = count;
    prog_next   = prog;
    done_next   = 1'b0;
    err_next    = 1'b0;

    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          state_next  = SHIFT;
          count_next  = '0;
          shadow_next = '0;
        end
      end

      SHIFT: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end else if (cfg_valid) begin
          shadow_next = {shadow[PROG_W-2:0], cfg_bit};
          count_next  = count + CNT_W'(1);
          if (count == LAST_BIT) state_next = PARITY;
        end
      end

      PARITY: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end else if (cfg_valid) begin
          if (((^shadow) ^ cfg_bit) == 1'b0) begin
            state_next = COMMIT;
          end else begin
            state_next = IDLE;
            err_next   = 1'b1;
          end
        end
      end

      COMMIT: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end else if (apply_ok) begin
          prog_next  = shadow;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // Busy is registered from the next state so it drops in the same cycle
    // that done or err rises.
    busy_next = (state_next != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      count    <= '0;
      prog     <= '0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_next;
      shadow   <= shadow_next;
      count    <= count_next;
      prog     <= prog_next;
      cfg_busy <= busy_next;
      cfg_done <= done_next;
      cfg_err  <= err_next;
    end
  end

endmodule

// File: tb/tb_sb_cfg_loader.sv
// Self-checking bench for sb_cfg_loader: directed frames from the test plan
// plus randomized frames checked against a frame-level expectation model.
module tb_sb_cfg_loader;

  logic        clk;
  logic        rst_n;
  logic        cfg_start, cfg_valid, cfg_bit, cfg_abort, apply_ok;
  logic [31:0] prog;
  logic        cfg_busy, cfg_done, cfg_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_prog = '0;

  sb_cfg_loader #(.PROG_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_abort (cfg_abort),
    .apply_ok  (apply_ok),
    .prog      (prog),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic busy, input logic done, input logic err);
    check({tag, ".prog"}, prog, exp_prog);
    check({tag, ".busy"}, 32'(cfg_busy), 32'(busy));
    check({tag, ".done"}, 32'(cfg_done), 32'(done));
    check({tag, ".err"},  32'(cfg_err),  32'(err));
  endtask

  // One clock: outputs are examined 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stray start, then abort together with valid/apply_ok/start: all ignored but the abort.
  task automatic do_abort(input string tag);
    cfg_start = 1'b1; cfg_valid = 1'b0; cfg_abort = 1'b0;
    step();
    chk_out({tag, ".stray_start"}, 1'b1, 1'b0, 1'b0);
    cfg_start = 1'b1; cfg_abort = 1'b1; cfg_valid = 1'b1;
    cfg_bit = 1'($urandom); apply_ok = 1'b1;
    step();
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; apply_ok = 1'b0;
    chk_out({tag, ".abort"}, 1'b0, 1'b0, 1'b0);
    step();
    chk_out({tag, ".after_abort"}, 1'b0, 1'b0, 1'b0);
  endtask

  // Frame model: abort_at in 0..31 aborts before that data bit, 32 aborts in
  // PARITY, 33 aborts in COMMIT, -1 never aborts. gap_mode 0 none, 1 one idle
  // cycle before every bit, 2 random gaps.
  task automatic run_frame(input logic [31:0] w, input bit good_par, input int gap_mode,
                           input int apply_wait, input int abort_at);
    logic par;
    int   gaps;
    par = (^w) ^ ~good_par;

    cfg_start = 1'b1; cfg_valid = 1'($urandom); cfg_bit = 1'($urandom);
    apply_ok = 1'($urandom); cfg_abort = 1'b0;
    step();
    cfg_start = 1'b0;
    chk_out("start", 1'b1, 1'b0, 1'b0);

    for (int i = 31; i >= 0; i--) begin
      if (abort_at == 31 - i) begin
        do_abort("abort_shift");
        return;
      end
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        cfg_valid = 1'b0; cfg_bit = 1'($urandom);
        cfg_start = ($urandom_range(0, 3) == 0);
        step();
        cfg_start = 1'b0;
        check("gap.busy", 32'(cfg_busy), 32'd1);
      end
      cfg_valid = 1'b1; cfg_bit = w[i]; apply_ok = 1'($urandom);
      step();
      cfg_valid = 1'b0;
    end
    chk_out("shifted", 1'b1, 1'b0, 1'b0);

    if (abort_at == 32) begin
      do_abort("abort_parity");
      return;
    end

    cfg_valid = 1'b1; cfg_bit = par; apply_ok = 1'b0;
    step();
    cfg_valid = 1'b0;
    if (!good_par) begin
      chk_out("parity_bad", 1'b0, 1'b0, 1'b1);
      return;
    end
    chk_out("parity_ok", 1'b1, 1'b0, 1'b0);

    if (abort_at == 33) begin
      do_abort("abort_commit");
      return;
    end

    for (int k = 0; k < apply_wait; k++) begin
      apply_ok = 1'b0; cfg_valid = 1'($urandom); cfg_bit = 1'($urandom);
      step();
      chk_out("apply_wait", 1'b1, 1'b0, 1'b0);
    end
    cfg_valid = 1'b0; apply_ok = 1'b1;
    step();
    apply_ok = 1'b0;
    exp_prog = w;
    chk_out("commit", 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    cfg_abort = 1'b0; apply_ok = 1'b0;
    #3;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    #9 rst_n = 1'b1;
    step();
    chk_out("post_reset", 1'b0, 1'b0, 1'b0);

    // Abort and valid bits in IDLE do nothing.
    cfg_abort = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1; apply_ok = 1'b1;
    step();
    cfg_abort = 1'b0; cfg_valid = 1'b0; apply_ok = 1'b0;
    chk_out("idle_abort", 1'b0, 1'b0, 1'b0);

    run_frame(32'hA5C30F1E, 1'b1, 0, 0, -1);
    run_frame(32'h00000001, 1'b0, 1, 0, -1);
    step();
    chk_out("err_one_cycle", 1'b0, 1'b0, 1'b0);
    run_frame(32'hFFFF0000, 1'b1, 0, 5, -1);
    run_frame(32'hDEADBEEF, 1'b1, 0, 0, 10);
    run_frame(32'h12345678, 1'b1, 0, 0, -1);

    // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    exp_prog = '0;
    chk_out("async_reset", 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    for (int n = 0; n < 25; n++) begin
      logic [31:0] w;
      int          ab;
      w  = $urandom;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 33)) : -1;
      run_frame(w, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 4)), ab);
    end

    // Reset in the middle of a frame: no partial commit, stray bits ignored after.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 31; i > 11; i--) begin
      logic [31:0] pat;
      pat = 32'h0F0F0F0F;
      cfg_valid = 1'b1; cfg_bit = pat[i];
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    exp_prog = '0;
    chk_out("reset_mid_frame", 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'($urandom); apply_ok = 1'($urandom);
      step();
      chk_out("no_start", 1'b0, 1'b0, 1'b0);
    end
    cfg_valid = 1'b0; apply_ok = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
